// File: rtl/spin_readout.sv
// Readout engine for the oscillator Ising array: counts phase mismatches of each oscillator
// against the reference over a programmable window and majority-decodes them into spin bits.
module spin_readout #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     osc,
  input  logic             ref_osc,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [N-1:0]     spins
);

  typedef enum logic [1:0] {StIdle, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     osc_meta_q, s_osc_q;
  logic             ref_meta_q, s_ref_q;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [CNT_W-1:0] cnt_inc [N];
  logic [N-1:0]     spins_q, spins_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     mism;
  logic [CNT_W-1:0] smp_inc;
  logic             last_smp;

  assign mism     = s_osc_q ^ {N{s_ref_q}};
  assign smp_inc  = smp_q + CNT_W'(1);
  assign last_smp = (smp_inc == win_q);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_inc[i] = cnt_q[i] + CNT_W'(mism[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    smp_d   = smp_q;
    spins_d = spins_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d  = window_len;
          smp_d  = '0;
          busy_d = 1'b1;
          for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
          end
          if (window_len == '0) begin
            state_d = StDone;
            valid_d = 1'b1;
            spins_d = '0;
          end else begin
            state_d = StSample;
          end
        end
      end
      StSample: begin
        smp_d = smp_inc;
        for (int i = 0; i < N; i++) begin
          cnt_d[i] = cnt_inc[i];
        end
        if (last_smp) begin
          // Majority at CNT_W+1 bits: exactly half the window decodes to 0.
          for (int i = 0; i < N; i++) begin
            spins_d[i] = {cnt_inc[i], 1'b0} > {1'b0, win_q};
          end
          state_d = StDone;
          valid_d = 1'b1;
        end
      end
      StDone: begin
        if (ready) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_meta_q <= '0;
      s_osc_q    <= '0;
      ref_meta_q <= 1'b0;
      s_ref_q    <= 1'b0;
      state_q    <= StIdle;
      win_q      <= '0;
      smp_q      <= '0;
      spins_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      osc_meta_q <= osc;
      s_osc_q    <= osc_meta_q;
      ref_meta_q <= ref_osc;
      s_ref_q    <= ref_meta_q;
      state_q    <= state_d;
      win_q      <= win_d;
      smp_q      <= smp_d;
      spins_q    <= spins_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign spins = spins_q;

endmodule

// File: tb/tb_spin_readout.sv
// Scoreboard bench for spin_readout: each window's expected spins and valid edge are derived
// from the driven pattern, which the DUT sees two edges late through its synchronizers.
module tb_spin_readout;
  localparam int N     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     osc = '0;
  logic             ref_osc = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] window_len = '0;
  logic             busy, valid;
  logic             ready = 1'b0;
  logic [N-1:0]     spins;

  spin_readout #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .osc        (osc),
    .ref_osc    (ref_osc),
    .start      (start),
    .window_len (window_len),
    .busy       (busy),
    .valid      (valid),
    .ready      (ready),
    .spins      (spins)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] spins;
    int           vedge;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           edge_cnt = 0;
  logic         hs_pend = 1'b0;
  logic [N-1:0] pat_osc [0:63];
  logic         pat_ref [0:63];

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rising valid, checks spins stay held while valid.
  initial begin
    logic         pv;
    logic [N-1:0] hold;
    exp_t         e;
    pv   = 1'b0;
    hold = '0;
    forever begin
      @(posedge clk);
      #1;
      if (valid && !pv) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1, expected no readout (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("spins", 32'(spins), 32'(e.spins));
          chk("valid_edge", edge_cnt, e.vedge);
          hold = e.spins;
        end
      end else if (valid && pv) begin
        chk("spins_hold", 32'(spins), 32'(hold));
      end
      if (valid) chk("busy_in_done", 32'(busy), 32'd1);
      pv = valid;
    end
  end

  task automatic drive(input int j, input int w);
    if (j < w) begin
      osc     = pat_osc[j];
      ref_osc = pat_ref[j];
    end else begin
      osc     = N'($urandom);
      ref_osc = 1'($urandom);
    end
  endtask

  task automatic fill_random(input int w);
    int prob [N];
    logic r;
    for (int i = 0; i < N; i++) prob[i] = $urandom_range(0, 100);
    for (int j = 0; j < w; j++) begin
      r = 1'($urandom);
      pat_ref[j] = r;
      for (int i = 0; i < N; i++) pat_osc[j][i] = r ^ (int'($urandom_range(0, 99)) < prob[i]);
    end
  endtask

  // Called just after a negedge with the DUT idle (or handshaking) at the next posedge.
  task automatic txn(input int w, input int hold);
    exp_t         e;
    logic [N-1:0] s;
    int           m;
    int           t;
    s = '0;
    for (int i = 0; i < N; i++) begin
      m = 0;
      for (int j = 0; j < w; j++) if (pat_osc[j][i] != pat_ref[j]) m++;
      s[i] = (2 * m > w);
    end
    drive(0, w);
    @(negedge clk);
    if (hs_pend) begin
      chk("valid_after_ack", 32'(valid), 32'd0);
      chk("busy_after_ack", 32'(busy), 32'd0);
      hs_pend = 1'b0;
    end
    ready      = 1'b0;
    start      = 1'b1;
    window_len = CNT_W'(w);
    drive(1, w);
    e.spins = s;
    e.vedge = edge_cnt + 1 + w;
    exp_q.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    window_len = CNT_W'($urandom);
    drive(2, w);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_early", 32'(valid), 32'(w == 0));
    for (int j = 3; j < w; j++) begin
      @(negedge clk);
      drive(j, w);
    end
    t = 0;
    while (!valid && t < w + 8) begin
      @(negedge clk);
      drive(w, w);
      t++;
    end
    if (!valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: got valid=0 after %0d cycles, expected valid for W=%0d", t, w);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = 1'($urandom);
      drive(w, w);
    end
    start   = 1'b0;
    ready   = 1'b1;
    hs_pend = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_spins", 32'(spins), 32'd0);
    rst_n = 1'b1;

    // All in phase, square wave of period 7.
    for (int j = 0; j < 10; j++) begin
      pat_ref[j] = ((j % 7) < 4);
      pat_osc[j] = {N{pat_ref[j]}};
    end
    txn(10, 5);

    // Tie-break: osc[0] 2 of 4 mismatches, osc[1] 3 of 4.
    for (int j = 0; j < 4; j++) begin
      logic a, b;
      a = (j < 2);
      b = (j < 3);
      pat_ref[j] = 1'(j & 1);
      pat_osc[j] = {N{pat_ref[j]}} ^ N'({b, a});
    end
    txn(4, 2);

    txn(0, 3);

    for (int k = 0; k < 20; k++) begin
      int w;
      w = $urandom_range(0, 40);
      fill_random(w);
      txn(w, $urandom_range(0, 5));
    end

    // osc[3] anti-phase; leaves spins nonzero ahead of the reset check.
    for (int j = 0; j < 20; j++) begin
      pat_ref[j] = ((j % 7) < 4);
      pat_osc[j] = {N{pat_ref[j]}} ^ N'(8'h08);
    end
    txn(20, 1);

    // Reset during sampling of a W=16 window.
    fill_random(16);
    drive(0, 16);
    @(negedge clk);
    ready      = 1'b0;
    hs_pend    = 1'b0;
    start      = 1'b1;
    window_len = CNT_W'(16);
    drive(1, 16);
    for (int j = 2; j < 7; j++) begin
      @(negedge clk);
      start = 1'b0;
      drive(j, 16);
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_spins", 32'(spins), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_random(8);
    txn(8, 2);
    fill_random(12);
    txn(12, 0);

    @(negedge clk);
    ready = 1'b0;
    chk("final_valid", 32'(valid), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
